ysyx_22040632_mem_arb: RTL and testbench

//  Arbiter/sequencer sharing one memory port between the IFU (instruction fetch) and the EXU

---
 rtl/ysyx_22040632_mem_arb.sv | 179 +++++++++++++++++
 tb/tb_ysyx_22040632_mem_arb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040632_mem_arb.sv
// ---------------------------------------------------------------------------
// ysyx_22040632_mem_arb
//
// Shares a single memory port between the instruction fetch unit (IFU) and
// the load/store path (LSU). Only one transaction is in flight at a time:
// IDLE picks a winner and latches its request, REQ presents it to memory
// until accepted, RESP waits for the response and routes it back to the
// owner. A response timeout returns an error strobe so that a hung memory
// cannot deadlock the core.
//
// Configuration macro:
//   YSYX_22040632_ARB_RR_EN  defined   -> round-robin on simultaneous requests
//                            undefined -> fixed priority, LSU over IFU
//
// Parameters:
//   AW      address width
//   DW      data width (DW/8 byte-mask lanes)
//   TO_CYC  RESP cycles without a response before timing out (0 = never)
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req_valid/if_req_ready      IFU request handshake, if_addr
//   if_rsp_valid/if_rsp_data       IFU one-cycle response strobe and data
//   ls_req_valid/ls_req_ready      LSU request handshake
//   ls_addr/ls_wen/ls_wdata/ls_wmask  LSU request fields (wen=1 store)
//   ls_rsp_valid/ls_rsp_data       LSU one-cycle response (also store ack)
//   rsp_err                        qualifies the response: 1 = timed out
//   mem_req_valid/mem_req_ready    memory request handshake
//   mem_addr/mem_wen/mem_wdata/mem_wmask  registered request fields
//   mem_rsp_valid/mem_rsp_data     memory response
//   busy                           a transaction is in progress
// ---------------------------------------------------------------------------
module ysyx_22040632_mem_arb #(
  parameter int AW     = 64,
  parameter int DW     = 64,
  parameter int TO_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  // IFU side
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [AW-1:0]   if_addr,
  output logic            if_rsp_valid,
  output logic [DW-1:0]   if_rsp_data,
  // load/store side
  input  logic            ls_req_valid,
  output logic            ls_req_ready,
  input  logic [AW-1:0]   ls_addr,
  input  logic            ls_wen,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_wmask,
  output logic            ls_rsp_valid,
  output logic [DW-1:0]   ls_rsp_data,
  output logic            rsp_err,
  // memory side
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_rsp_valid,
  input  logic [DW-1:0]   mem_rsp_data,
  output logic            busy
);

  localparam int MW = DW / 8;
  // Counter wide enough to reach TO_CYC; at least one bit so that the
  // disabled case (TO_CYC = 0) still elaborates.
  localparam int CW = (TO_CYC < 2) ? 1 : $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TO_CYC);
  localparam bit TO_EN = (TO_CYC != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_reg;
  logic            owner_ls_reg;   // 1 = LSU owns the transaction
  logic [AW-1:0]   addr_reg;
  logic            wen_reg;
  logic [DW-1:0]   wdata_reg;
  logic [MW-1:0]   wmask_reg;
  logic [CW-1:0]   cnt_reg;

  logic            any_req;
  logic            grant_ls;
  logic            grant_if;
  logic            accept;
  logic            timeout_hit;
  logic            rsp_fire;
  logic [DW-1:0]   rsp_data;

  assign any_req = if_req_valid | ls_req_valid;

`ifdef YSYX_22040632_ARB_RR_EN
  logic last_ls_reg;               // 1 = LSU won the most recent grant
  // On a tie the side that did not win last time goes first.
  assign grant_ls = ls_req_valid & (~if_req_valid | ~last_ls_reg);
`else
  assign grant_ls = ls_req_valid;
`endif
  assign grant_if = if_req_valid & ~grant_ls;

  // Grants are only offered in IDLE; reset masks them so nothing is
  // accepted in a cycle whose state update is being discarded.
  assign accept       = (state_reg == IDLE) & ~rst;
  assign if_req_ready = accept & grant_if;
  assign ls_req_ready = accept & grant_ls;

  // A real response in the same cycle as the timeout takes precedence.
  assign timeout_hit = TO_EN && (state_reg == RESP) && (cnt_reg == TO_LIM)
                       && !mem_rsp_valid;
  assign rsp_fire    = (state_reg == RESP) & ~rst & (mem_rsp_valid | timeout_hit);
  assign rsp_err     = rsp_fire & ~mem_rsp_valid;
  assign rsp_data    = (rsp_fire & mem_rsp_valid) ? mem_rsp_data : '0;

  assign if_rsp_valid = rsp_fire & ~owner_ls_reg;
  assign ls_rsp_valid = rsp_fire & owner_ls_reg;
  assign if_rsp_data  = if_rsp_valid ? rsp_data : '0;
  assign ls_rsp_data  = ls_rsp_valid ? rsp_data : '0;

  assign mem_req_valid = (state_reg == REQ);
  assign mem_addr      = addr_reg;
  assign mem_wen       = wen_reg;
  assign mem_wdata     = wdata_reg;
  assign mem_wmask     = wmask_reg;
  assign busy          = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      owner_ls_reg <= 1'b0;
      addr_reg     <= '0;
      wen_reg      <= 1'b0;
      wdata_reg    <= '0;
      wmask_reg    <= '0;
      cnt_reg      <= '0;
`ifdef YSYX_22040632_ARB_RR_EN
      last_ls_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            owner_ls_reg <= grant_ls;
            // IFU requests are always reads: no write enable, no mask.
            addr_reg     <= grant_ls ? ls_addr : if_addr;
            wen_reg      <= grant_ls & ls_wen;
            wdata_reg    <= grant_ls ? ls_wdata : '0;
            wmask_reg    <= grant_ls ? ls_wmask : '0;
            state_reg    <= REQ;
`ifdef YSYX_22040632_ARB_RR_EN
            last_ls_reg  <= grant_ls;
`endif
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state_reg <= RESP;
            cnt_reg   <= '0;
          end
        end
        RESP: begin
          if (mem_rsp_valid || timeout_hit) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040632_mem_arb.sv
module tb_ysyx_22040632_mem_arb;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 4;
`ifdef YSYX_22040632_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req_valid, if_req_ready, if_rsp_valid;
  logic [AW-1:0]   if_addr;
  logic [DW-1:0]   if_rsp_data;
  logic            ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid;
  logic [AW-1:0]   ls_addr;
  logic [DW-1:0]   ls_wdata, ls_rsp_data;
  logic [DW/8-1:0] ls_wmask;
  logic            rsp_err;
  logic            mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rsp_data;
  logic [DW/8-1:0] mem_wmask;
  logic            busy;

  ysyx_22040632_mem_arb #(.AW(AW), .DW(DW), .TO_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data), .rsp_err(rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          ifv;
    bit          lsv;
    logic [63:0] if_a;
    logic [63:0] ls_a;
    bit          wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    int          rdy_dly;   // REQ cycles with mem_req_ready low
    int          rsp_dly;   // RESP cycles before mem_rsp_valid
    bit          to;        // memory never answers
    logic [63:0] rdata;
    bit          exp_ls;    // expected winner: 1 = LSU
  } vec_t;

  vec_t vecs[10];

  // Entered at #1 after a posedge with the DUT in IDLE; leaves at #1 after
  // the posedge that ends the response cycle (DUT back in IDLE).
  task automatic run_txn(input int idx, input vec_t v);
    logic [63:0] e_addr, e_wdata;
    logic [7:0]  e_mask;
    logic        e_wen;
    int          n;
    e_addr  = v.exp_ls ? v.ls_a : v.if_a;
    e_wen   = v.exp_ls & v.wen;
    e_wdata = v.exp_ls ? v.wdata : 64'h0;
    e_mask  = v.exp_ls ? v.wmask : 8'h0;
    if_req_valid  = v.ifv;
    if_addr       = v.if_a;
    ls_req_valid  = v.lsv;
    ls_addr       = v.ls_a;
    ls_wen        = v.wen;
    ls_wdata      = v.wdata;
    ls_wmask      = v.wmask;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = v.rdata;
    @(negedge clk);
    check1("busy_idle", busy, 1'b0);
    check1("if_req_ready", if_req_ready, !v.exp_ls);
    check1("ls_req_ready", ls_req_ready, v.exp_ls);
    check1("mem_req_valid_accept", mem_req_valid, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i <= v.rdy_dly; i++) begin
      mem_req_ready = (i == v.rdy_dly);
      @(negedge clk);
      check1("mem_req_valid", mem_req_valid, 1'b1);
      check64("mem_addr", mem_addr, e_addr);
      check1("mem_wen", mem_wen, e_wen);
      check64("mem_wdata", mem_wdata, e_wdata);
      check64("mem_wmask", {56'h0, mem_wmask}, {56'h0, e_mask});
      check1("req_ready_busy", if_req_ready | ls_req_ready, 1'b0);
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;
    n = v.to ? TO : v.rsp_dly;
    for (int i = 0; i <= n; i++) begin
      mem_rsp_valid = !v.to && (i == n);
      @(negedge clk);
      check1("mem_req_valid_resp", mem_req_valid, 1'b0);
      check1("owner_rsp_valid", v.exp_ls ? ls_rsp_valid : if_rsp_valid, i == n);
      check1("other_rsp_valid", v.exp_ls ? if_rsp_valid : ls_rsp_valid, 1'b0);
      check1("rsp_err", rsp_err, (i == n) && v.to);
      if (i == n)
        check64("rsp_data", v.exp_ls ? ls_rsp_data : if_rsp_data, v.to ? 64'h0 : v.rdata);
      @(posedge clk); #1;
    end
    mem_rsp_valid = 1'b0;
    $display("txn %0d: owner=%s addr=0x%0h wen=%0b to=%0b errors=%0d",
             idx, v.exp_ls ? "LSU" : "IFU", e_addr, e_wen, v.to, errors);
  endtask

  initial begin
    vec_t rec;
    //              ifv lsv if_a                ls_a                wen wdata        wmask  rdy rsp to rdata                   exp_ls
    vecs[0] = '{1'b1, 1'b0, 64'h8000_0000, 64'h0,         1'b0, 64'h0,      8'h00, 0, 1, 1'b0, 64'h13,                 1'b0};
    vecs[1] = '{1'b1, 1'b1, 64'h8000_0004, 64'h8000_0100, 1'b1, 64'hDEAD,   8'hFF, 0, 0, 1'b0, 64'h55,                 1'b1};
    vecs[2] = '{1'b1, 1'b0, 64'h8000_0004, 64'h0,         1'b0, 64'h0,      8'h00, 0, 0, 1'b0, 64'h0000_0297,          1'b0};
    vecs[3] = '{1'b0, 1'b1, 64'h0,         64'h8000_0200, 1'b0, 64'h0,      8'h00, 5, 2, 1'b0, 64'h1122_3344_5566_7788, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 64'h8000_0008, 64'h0,         1'b0, 64'h0,      8'h00, 0, 0, 1'b1, 64'hFFFF,               1'b0};
    vecs[5] = '{1'b0, 1'b1, 64'h0,         64'h8000_0300, 1'b1, 64'hBEEF,   8'h0F, 1, 0, 1'b1, 64'hFFFF,               1'b1};
    vecs[6] = '{1'b1, 1'b1, 64'h8000_0010, 64'h8000_0400, 1'b0, 64'h0,      8'h00, 0, 0, 1'b0, 64'hA1,                 !RR};
    vecs[7] = '{1'b1, 1'b1, 64'h8000_0010, 64'h8000_0400, 1'b0, 64'h0,      8'h00, 0, 0, 1'b0, 64'hA2,                 1'b1};
    vecs[8] = '{1'b1, 1'b1, 64'h8000_0010, 64'h8000_0400, 1'b0, 64'h0,      8'h00, 0, 0, 1'b0, 64'hA3,                 !RR};
    vecs[9] = '{1'b1, 1'b1, 64'h8000_0010, 64'h8000_0400, 1'b0, 64'h0,      8'h00, 0, 0, 1'b0, 64'hA4,                 1'b1};

    rst = 1'b1;
    if_req_valid = 1'b0; if_addr = '0;
    ls_req_valid = 1'b0; ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check1("rst_busy", busy, 1'b0);
    check1("rst_mem_req_valid", mem_req_valid, 1'b0);
    check64("rst_mem_addr", mem_addr, 64'h0);
    check1("rst_mem_wen", mem_wen, 1'b0);
    check64("rst_mem_wdata", mem_wdata, 64'h0);
    check64("rst_mem_wmask", {56'h0, mem_wmask}, 64'h0);
    check1("rst_rsp_valid", if_rsp_valid | ls_rsp_valid, 1'b0);
    check1("rst_rsp_err", rsp_err, 1'b0);
    check1("rst_req_ready", if_req_ready | ls_req_ready, 1'b0);
    @(posedge clk); #1;

    for (int k = 0; k < 10; k++) run_txn(k, vecs[k]);

    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    @(negedge clk);
    check1("post_table_busy", busy, 1'b0);
    @(posedge clk); #1;

    // Reset in the middle of RESP, followed by a stale memory response.
    if_req_valid = 1'b1;
    if_addr = 64'h8000_0040;
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    check1("rst_mid_busy_before", busy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 64'hBAD;
    @(negedge clk);
    check1("stale_if_rsp", if_rsp_valid, 1'b0);
    check1("stale_ls_rsp", ls_rsp_valid, 1'b0);
    check1("stale_rsp_err", rsp_err, 1'b0);
    check1("stale_busy", busy, 1'b0);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check1("after_stale_busy", busy, 1'b0);
    check1("after_stale_mem_req", mem_req_valid, 1'b0);
    @(posedge clk); #1;
    $display("txn rst: reset in RESP, stale response dropped errors=%0d", errors);

    // Normal operation resumes after the abandoned transaction.
    rec = '{1'b1, 1'b0, 64'h8000_0080, 64'h0, 1'b0, 64'h0, 8'h00, 0, 0, 1'b0, 64'h77, 1'b0};
    run_txn(10, rec);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
